toccata_sample_fifo: RTL

TOCCATA_SAMPLE_FIFO -- requirements
Module: toccata_sample_fifo

---
 rtl/toccata_pkg.sv | 19 +
 rtl/toccata_fifo_ram.sv | 35 +++
 rtl/toccata_sample_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/toccata_pkg.sv
// toccata_pkg: shared audio sample/frame types and default frame geometry
// for the Toccata audio datapath.
package toccata_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int CHANNELS_DEF     = 2;
    localparam int FRAME_WIDTH_DEF  = SAMPLE_WIDTH_DEF * CHANNELS_DEF;

    typedef logic [SAMPLE_WIDTH_DEF-1:0] sample_t;

    // One multichannel frame, channel 0 in the least significant bits.
    typedef logic [FRAME_WIDTH_DEF-1:0] frame_t;

    // Extract one channel's sample from a default-geometry frame.
    function automatic sample_t frame_channel(input frame_t f, input int ch);
        return f[ch*SAMPLE_WIDTH_DEF +: SAMPLE_WIDTH_DEF];
    endfunction

endpackage

// File: rtl/toccata_fifo_ram.sv
// toccata_fifo_ram: simple dual-port frame storage, one write port and one
// registered read port, written so that it maps onto block RAM. The array
// has no reset; the read register holds its value while re is low.
module toccata_fifo_ram
    import toccata_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH_DEF,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/toccata_sample_fifo.sv
// toccata_sample_fifo: first-word-fall-through audio frame FIFO with level,
// watermark pulses and sticky error flags. Storage is a registered-read RAM
// followed by a two-stage prefetch (RAM read register, output register).
// Optional statistics counters are built when TOCCATA_FIFO_STATS_EN is defined.
//
// Handshake: rd_valid means rd_data holds the head frame; a read is taken on
// a rising edge where rd_en && rd_valid. A write is taken on a rising edge
// where wr_en && (!full || read taken in the same edge). flush and rst make
// the same edge ignore wr_en/rd_en.
module toccata_sample_fifo
    import toccata_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int CHANNELS     = CHANNELS_DEF,
    parameter int DEPTH        = 1024,
    localparam int FW          = CHANNELS * SAMPLE_WIDTH,
    localparam int AW          = $clog2(DEPTH),
    localparam int LW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [FW-1:0] wr_data,
    input  logic          rd_en,
    output logic [FW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    input  logic [LW-1:0] hi_thresh,
    input  logic [LW-1:0] lo_thresh,
    output logic          irq_hi,
    output logic          irq_lo,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow
`ifdef TOCCATA_FIFO_STATS_EN
    ,
    output logic [15:0]   ovf_count,
    output logic [15:0]   udf_count
`endif
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, ram_count;
    logic          ram_valid_q, ram_valid_d, out_valid_q, out_valid_d;
    logic [FW-1:0] out_data_q, out_data_d, ram_rdata;
    logic          irq_hi_q, irq_hi_d, irq_lo_q, irq_lo_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          full_w, rd_accept, wr_accept, ovf_event, udf_event;
    logic          stage_move, fetch;

    toccata_fifo_ram #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (fetch),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Accept decisions, prefetch movement and next-state for all flops.
    always_comb begin
        full_w     = (level_q == LW'(DEPTH));
        rd_accept  = rd_en && out_valid_q && !flush;
        wr_accept  = wr_en && !flush && (!full_w || rd_accept);
        ovf_event  = wr_en && !flush && !wr_accept;
        udf_event  = rd_en && !flush && !out_valid_q;
        // Frames still sitting in RAM, not yet pulled into the prefetch stages.
        ram_count  = level_q - LW'(ram_valid_q) - LW'(out_valid_q);
        stage_move = ram_valid_q && (!out_valid_q || rd_accept);
        fetch      = !flush && (ram_count != '0) && (!ram_valid_q || stage_move);

        wr_ptr_d    = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = fetch ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q + LW'(wr_accept) - LW'(rd_accept);
        ram_valid_d = fetch ? 1'b1 : (stage_move ? 1'b0 : ram_valid_q);
        out_valid_d = stage_move ? 1'b1 : (rd_accept ? 1'b0 : out_valid_q);
        out_data_d  = stage_move ? ram_rdata : out_data_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            ram_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end

        // Pulses depend on a level transition, so a threshold change alone
        // (level_q == level_d) can never satisfy both sides.
        irq_hi_d    = !flush && (level_q <= hi_thresh) && (level_d > hi_thresh);
        irq_lo_d    = !flush && (level_q >= lo_thresh) && (level_d < lo_thresh);
        // A same-cycle error wins over err_clr.
        overflow_d  = ovf_event || (!err_clr && overflow_q);
        underflow_d = udf_event || (!err_clr && underflow_q);
    end

    // State registers; rst dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ram_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            irq_hi_q    <= 1'b0;
            irq_lo_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ram_valid_q <= ram_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            irq_hi_q    <= irq_hi_d;
            irq_lo_q    <= irq_lo_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data   = out_data_q;
    assign rd_valid  = out_valid_q;
    assign level     = level_q;
    assign full      = full_w;
    assign empty     = (level_q == '0);
    assign irq_hi    = irq_hi_q;
    assign irq_lo    = irq_lo_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef TOCCATA_FIFO_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;

    // Saturating error counters; an event in the err_clr cycle still counts.
    always_comb begin
        ovf_cnt_d = err_clr ? 16'd0 : ovf_cnt_q;
        udf_cnt_d = err_clr ? 16'd0 : udf_cnt_q;
        if (ovf_event && ovf_cnt_d != 16'hFFFF) ovf_cnt_d = ovf_cnt_d + 16'd1;
        if (udf_event && udf_cnt_d != 16'hFFFF) udf_cnt_d = udf_cnt_d + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
    assign udf_count = udf_cnt_q;
`endif

endmodule
